video_timing_gen: RTL and testbench
===================================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 800: visible pixels per line.
REQ-002 Parameter H_FP, default 40: horizontal front porch, in pixels.
REQ-003 Parameter H_SYNC, default 48: hsync pulse width, in pixels.
REQ-004 Parameter H_BP, default 88: horizontal back porch, in pixels.
REQ-005 Parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/13/3/32: the same four quantities in lines.
REQ-006 Parameters HS_POL and VS_POL, default 0: the asserted sync level (1 = active-high, 0 = active-low).
REQ-007 Parameter COORD_W, default 12: width of the coordinate and counter fields.
REQ-008 clk  input  1  single clock; all logic is on the rising edge.
REQ-009 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-010 ce  input  1  pixel clock-enable; timing advances only on cycles with ce=1.
REQ-011 en  input  1  run enable; low holds the generator idle at frame origin.
REQ-012 hsync, vsync  output  1 each  sync outputs, polarity per HS_POL/VS_POL.
REQ-013 de  output  1  data enable; high only for visible pixels.
REQ-014 vblank  output  1  high for every line with v >= V_ACTIVE.
REQ-015 x, y  output  COORD_W each  visible pixel coordinate; 0 outside the visible area.
REQ-016 line_start, frame_start  output  1 each  single-cycle pulses.

Function
REQ-017 Horizontal counter h runs 0..H_TOT-1 with H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP; vertical counter v runs 0..V_TOT-1, defined likewise.
REQ-018 On a ce=1, en=1 edge: h increments; at h=H_TOT-1, h wraps to 0 and v increments; at v=V_TOT-1 with that wrap, v wraps to 0.
REQ-019 Line order is active, front porch, sync, back porch, for both axes.
REQ-020 All outputs are registered; each is a decode of the (h,v) value held before the same ce=1 edge, so latency is 1 enabled cycle.
REQ-021 de=1 iff h<H_ACTIVE and v<V_ACTIVE.
REQ-022 x=h when de would be 1, otherwise 0; y=v when de would be 1, otherwise 0.
REQ-023 hsync is at its asserted level iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, on every line including blanking lines.
REQ-024 vsync is at its asserted level iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, for all h, so it changes only at line boundaries.
REQ-025 line_start=1 for exactly the cycle whose decode has h=0; frame_start=1 only when h=0 and v=0.
REQ-026 On a ce=0 cycle, counters and level outputs hold, and line_start/frame_start are forced to 0 (no pulse stretching).
REQ-027 On an en=0 edge, independent of ce, the generator behaves as follows:
- h and v are synchronously cleared to 0;
- de, vblank, line_start and frame_start are driven to 0, and x, y to 0;
- hsync and vsync are driven to their deasserted levels.
REQ-028 Deasserting en mid-frame aborts the frame immediately; there is no completion of the current line.
REQ-029 On the first ce=1, en=1 edge after en rises, the outputs decode (0,0): frame_start=1, line_start=1, de=1.
REQ-030 Elaboration fails if any timing parameter is < 1, or if H_TOT or V_TOT >= 2**COORD_W.

Reset
REQ-031 While rst_n=0: h=v=0; de=vblank=line_start=frame_start=0; x=y=0; hsync=~HS_POL; vsync=~VS_POL.
REQ-032 rst_n assertion takes effect asynchronously at any point mid-frame; deassertion is assumed synchronised upstream.
REQ-033 The first ce=1, en=1 edge after reset release produces the REQ-029 origin outputs.

Structure
REQ-034 Shared package video_timing_pkg holds:
- default timing constants for the 800x480 mode;
- a 640x480 mode set;
- a function returning H_TOT/V_TOT.
REQ-035 One sub-module, video_axis_counter, is instantiated twice (h and v). It has:
- parameters ACTIVE/FP/SYNC/BP/W;
- inputs step and clear;
- outputs count, wrap, in_active and in_sync.

Verification
Bench parameters for all scenarios: H=8/2/3/1 (H_TOT=14), V=4/1/2/1 (V_TOT=8), HS_POL=0, VS_POL=1, ce=1 unless stated.
REQ-036 Release reset with en=1 -> first edge: frame_start=1, de=1, x=0, y=0. frame_start recurs every 112 cycles. line_start recurs every 14 cycles.
REQ-037 Run one line -> de high for 8 cycles (x=0..7). hsync low for cycles 10..12 of each line, high otherwise.
REQ-038 Run one frame -> vsync high for lines 5..6 (28 cycles). vblank high for lines 4..7. No de during lines 4..7.
REQ-039 Drive ce with 1-in-3 duty -> frame period is 336 clk cycles. Each pulse is 1 clk wide. Levels are identical to the ce=1 case, sampled on ce cycles.
REQ-040 Drop en at h=5, v=2 for 4 cycles, then raise it -> outputs idle (hsync=1, vsync=0, de=0) while en=0. The first enabled edge gives frame_start=1, x=0, y=0.
REQ-041 Assert rst_n=0 mid-line at h=9 with no clock edge -> all outputs reach their REQ-031 values immediately.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared timing constants and helpers for the raster timing generator.
package video_timing_pkg;

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 40;
  localparam int DEF_H_SYNC   = 48;
  localparam int DEF_H_BP     = 88;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 13;
  localparam int DEF_V_SYNC   = 3;
  localparam int DEF_V_BP     = 32;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  function automatic int axis_total(input int active, input int fp, input int sync,
                                    input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_timing_if.sv
// Video timing output bundle; master drives it, slave observes it.
interface video_timing_if #(
  parameter int COORD_W = 12
);
  logic               hsync;
  logic               vsync;
  logic               de;
  logic               vblank;
  logic               line_start;
  logic               frame_start;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;

  modport master (output hsync, vsync, de, vblank, line_start, frame_start, x, y);
  modport slave  (input  hsync, vsync, de, vblank, line_start, frame_start, x, y);
endinterface

// File: rtl/video_axis_counter.sv
// One raster axis: wrapping position counter with active and sync region decode.
module video_axis_counter #(
  parameter int ACTIVE = 8,
  parameter int FP     = 2,
  parameter int SYNC   = 3,
  parameter int BP     = 1,
  parameter int W      = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step,
  input  logic         clear,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         in_active,
  output logic         in_sync
);
  localparam int TOT = ACTIVE + FP + SYNC + BP;
  localparam logic [W-1:0] LAST    = W'(TOT - 1);
  localparam logic [W-1:0] ACT_END = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_LO = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_HI = W'(ACTIVE + FP + SYNC);

  assign wrap      = step && (count == LAST);
  assign in_active = count < ACT_END;
  assign in_sync   = (count >= SYNC_LO) && (count < SYNC_HI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (step) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end
endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters with registered sync, blanking and coordinate decode.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int COORD_W  = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ce,
  input  logic           en,
  video_timing_if.master vid
);
  localparam int H_TOT = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOT = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
    $error("video_timing_gen: every timing parameter must be at least 1");
  end
  if (H_TOT >= (2 ** COORD_W) || V_TOT >= (2 ** COORD_W)) begin : g_bad_width
    $error("video_timing_gen: COORD_W too narrow for the frame totals");
  end

  logic [COORD_W-1:0] h, v;
  logic               h_wrap, v_wrap;
  logic               h_act, v_act, h_sync, v_sync;
  logic               h_step;
  logic               vis;

  assign h_step = ce & en;
  assign vis    = h_act & v_act;

  video_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(COORD_W)
  ) u_h (
    .clk(clk), .rst_n(rst_n), .step(h_step), .clear(~en),
    .count(h), .wrap(h_wrap), .in_active(h_act), .in_sync(h_sync)
  );

  video_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(COORD_W)
  ) u_v (
    .clk(clk), .rst_n(rst_n), .step(h_wrap), .clear(~en),
    .count(v), .wrap(v_wrap), .in_active(v_act), .in_sync(v_sync)
  );

  // Outputs decode the pre-edge (h,v), giving one enabled cycle of latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid.de          <= 1'b0;
      vid.vblank      <= 1'b0;
      vid.line_start  <= 1'b0;
      vid.frame_start <= 1'b0;
      vid.x           <= '0;
      vid.y           <= '0;
      vid.hsync       <= ~HS_POL;
      vid.vsync       <= ~VS_POL;
    end else if (!en) begin
      vid.de          <= 1'b0;
      vid.vblank      <= 1'b0;
      vid.line_start  <= 1'b0;
      vid.frame_start <= 1'b0;
      vid.x           <= '0;
      vid.y           <= '0;
      vid.hsync       <= ~HS_POL;
      vid.vsync       <= ~VS_POL;
    end else if (ce) begin
      vid.de          <= vis;
      vid.vblank      <= ~v_act;
      vid.line_start  <= (h == '0);
      vid.frame_start <= (h == '0) && (v == '0);
      vid.x           <= vis ? h : '0;
      vid.y           <= vis ? v : '0;
      vid.hsync       <= h_sync ? HS_POL : ~HS_POL;
      vid.vsync       <= v_sync ? VS_POL : ~VS_POL;
    end else begin
      vid.line_start  <= 1'b0;
      vid.frame_start <= 1'b0;
    end
  end
endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a 14x8 raster (H 8/2/3/1, V 4/1/2/1).
module tb_video_timing_gen;
  localparam int CW = 12;
  localparam int HT = 14;
  localparam int FT = 112;

  logic clk = 1'b0;
  logic rst_n, ce, en;
  int   n_checks = 0;
  int   n_fail = 0;

  video_timing_if #(.COORD_W(CW)) vid ();

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b1), .COORD_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .en(en), .vid(vid)
  );

  always #5 clk = ~clk;

  // flags = {de, hsync, vsync, vblank, line_start, frame_start}
  typedef struct {
    int         idx;
    logic [5:0] flags;
    int         x;
    int         y;
  } vec_t;

  vec_t vecs[16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [5:0] flags, input int ex, input int ey);
    logic [5:0] got;
    got = {vid.de, vid.hsync, vid.vsync, vid.vblank, vid.line_start, vid.frame_start};
    n_checks++;
    if (got !== flags || int'(vid.x) != ex || int'(vid.y) != ey) begin
      n_fail++;
      $display("FAIL %s: got flags=%b x=%0d y=%0d, want flags=%b x=%0d y=%0d",
               name, got, vid.x, vid.y, flags, ex, ey);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ce    = 1'b1;
    en    = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  localparam logic [5:0] IDLE   = 6'b010000;
  localparam logic [5:0] ORIGIN = 6'b110011;

  initial begin
    int done;
    int c_de, c_hs, c_vs, c_vb, c_ls, c_fs;
    int first_fs, second_fs, wide, prev_fs, ls_in_frame, de_on_ce;

    vecs[0]  = '{0,        6'b110011, 0, 0};
    vecs[1]  = '{7,        6'b110000, 7, 0};
    vecs[2]  = '{8,        6'b010000, 0, 0};
    vecs[3]  = '{9,        6'b010000, 0, 0};
    vecs[4]  = '{HT+10,    6'b000000, 0, 0};
    vecs[5]  = '{HT+12,    6'b000000, 0, 0};
    vecs[6]  = '{HT+13,    6'b010000, 0, 0};
    vecs[7]  = '{2*HT,     6'b110010, 0, 2};
    vecs[8]  = '{3*HT+5,   6'b110000, 5, 3};
    vecs[9]  = '{4*HT,     6'b010110, 0, 0};
    vecs[10] = '{5*HT+3,   6'b011100, 0, 0};
    vecs[11] = '{5*HT+11,  6'b001100, 0, 0};
    vecs[12] = '{6*HT+13,  6'b011100, 0, 0};
    vecs[13] = '{7*HT,     6'b010110, 0, 0};
    vecs[14] = '{7*HT+13,  6'b010100, 0, 0};
    vecs[15] = '{FT,       6'b110011, 0, 0};

    // reset state, then walk one frame through the vector table
    rst_n = 1'b0; ce = 1'b1; en = 1'b1;
    #12;
    check("reset_idle", IDLE, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    done = 0;
    for (int i = 0; i < 16; i++) begin
      while (done < vecs[i].idx + 1) begin
        tick();
        done++;
      end
      check($sformatf("vec%0d_idx%0d", i, vecs[i].idx), vecs[i].flags, vecs[i].x, vecs[i].y);
    end

    // per-frame totals over one full period
    c_de = 0; c_hs = 0; c_vs = 0; c_vb = 0; c_ls = 0; c_fs = 0;
    repeat (FT) begin
      tick();
      c_de += int'(vid.de);
      c_hs += int'(!vid.hsync);
      c_vs += int'(vid.vsync);
      c_vb += int'(vid.vblank);
      c_ls += int'(vid.line_start);
      c_fs += int'(vid.frame_start);
    end
    check_int("frame_de_cycles", c_de, 32);
    check_int("frame_hsync_low", c_hs, 24);
    check_int("frame_vsync_high", c_vs, 28);
    check_int("frame_vblank", c_vb, 56);
    check_int("frame_line_starts", c_ls, 8);
    check_int("frame_frame_starts", c_fs, 1);

    // ce at 1-in-3 duty
    do_reset();
    first_fs = -1; second_fs = -1; wide = 0; prev_fs = 0; ls_in_frame = 0; de_on_ce = 0;
    for (int c = 0; c < 800; c++) begin
      ce = (c % 3 == 0);
      tick();
      if (vid.frame_start && prev_fs) wide++;
      if (vid.frame_start) begin
        if (first_fs < 0) first_fs = c;
        else if (second_fs < 0) second_fs = c;
      end
      if (first_fs >= 0 && second_fs < 0) begin
        ls_in_frame += int'(vid.line_start);
        if (ce) de_on_ce += int'(vid.de);
      end
      prev_fs = vid.frame_start;
    end
    ce = 1'b1;
    check_int("ce3_first_fs", first_fs, 0);
    check_int("ce3_frame_period", second_fs - first_fs, 336);
    check_int("ce3_wide_pulses", wide, 0);
    check_int("ce3_line_starts", ls_in_frame, 8);
    check_int("ce3_de_on_ce", de_on_ce, 32);

    // drop en with counters at h=5, v=2
    do_reset();
    repeat (2*HT + 5) tick();
    check("pre_drop_decode", 6'b110000, 4, 2);
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("en_low_idle%0d", k), IDLE, 0, 0);
    end
    en = 1'b1;
    tick();
    check("en_rise_origin", ORIGIN, 0, 0);
    tick();
    check("en_rise_second", 6'b110000, 1, 0);

    // async reset with counters at h=9, v=5 (vsync asserted)
    do_reset();
    repeat (5*HT + 9) tick();
    check("pre_rst_decode", 6'b011100, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_idle", IDLE, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_origin", ORIGIN, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
